// File: rtl/imem_fetch_unit.sv
// Sequential instruction fetch from a 1-cycle-latency memory into a small FIFO.
// Optional retired-fetch counter port enabled by IMEM_FETCH_COUNT_EN.
module imem_fetch_unit #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int RESET_PC   = 0
) (
    input  logic              clk0,
    input  logic              rstb0,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] dout0,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
`ifdef IMEM_FETCH_COUNT_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int OW = PW + 2;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] tag;
    logic [ADDR_W-1:0] addr_q;
    logic              inflight;
    logic              stale;
    logic [PW:0]       count;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];

    logic              pop;
    logic              push;
    logic              issue;
    logic [OW-1:0]     occ;
    logic [PW:0]       count_nxt;
    logic [PW-1:0]     rd_nxt;
    logic [PW-1:0]     wr_nxt;
    logic [DATA_W-1:0] head_data_nxt;
    logic [ADDR_W-1:0] head_pc_nxt;

    assign web0 = 1'b1;
    assign din0 = '0;

    assign inst_valid = (count != '0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    // A redirect in the response cycle drops the word along with the flush.
    assign push       = inflight && !stale && !redirect_valid;

    assign occ   = OW'(count) - OW'(pop) + OW'(inflight);
    assign issue = rstb0 && !redirect_valid && (occ < OW'(FIFO_DEPTH));

    assign csb0  = !issue;
    assign addr0 = issue ? fetch_pc : addr_q;

    always_comb begin
        rd_nxt        = rd_ptr + PW'(pop);
        wr_nxt        = wr_ptr + PW'(push);
        count_nxt     = count + (PW+1)'(push) - (PW+1)'(pop);
        head_data_nxt = data_mem[rd_nxt];
        head_pc_nxt   = pc_mem[rd_nxt];
        // Word being written lands straight at the head when the FIFO drains.
        if (push && (wr_ptr == rd_nxt)) begin
            head_data_nxt = dout0;
            head_pc_nxt   = tag;
        end
    end

    always_ff @(posedge clk0) begin
        if (push) begin
            data_mem[wr_ptr] <= dout0;
            pc_mem[wr_ptr]   <= tag;
        end
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            fetch_pc  <= ADDR_W'(RESET_PC);
            addr_q    <= '0;
            tag       <= '0;
            inflight  <= 1'b0;
            stale     <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            inst_data <= '0;
            inst_pc   <= '0;
        end else begin
            inflight <= issue;
            stale    <= redirect_valid && inflight;
            if (issue) begin
                addr_q   <= fetch_pc;
                tag      <= fetch_pc;
                fetch_pc <= fetch_pc + 1'b1;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                count  <= count_nxt;
                rd_ptr <= rd_nxt;
                wr_ptr <= wr_nxt;
                if (count_nxt != '0) begin
                    inst_data <= head_data_nxt;
                    inst_pc   <= head_pc_nxt;
                end
            end
        end
    end

`ifdef IMEM_FETCH_COUNT_EN
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            fetch_count <= '0;
        end else if (pop) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule
